// File: rtl/boruss_cpu_core.sv
// boruss_cpu_core: multi-cycle CPU with 16-bit instructions
// fetch/exec/mem sequencer over split instruction and data ports
module boruss_cpu_core #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int NUM_REGS = 4,
  localparam int RSEL_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        cpu_state,
  output logic [2:0]        flags,
  output logic              halted,
  output logic              retire,
  input  logic [RSEL_W-1:0] dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_EXEC  = 3'd1;
  localparam logic [2:0] S_MEM   = 3'd2;
  localparam logic [2:0] S_HALT  = 3'd3;

  localparam int IMD = (DATA_W < 8) ? DATA_W : 8;
  localparam int IMA = (ADDR_W < 8) ? ADDR_W : 8;

  logic [2:0]        st;
  logic [15:0]       ir;
  logic [DATA_W-1:0] regs [NUM_REGS];

  logic [3:0]        op;
  logic [RSEL_W-1:0] rd;
  logic [RSEL_W-1:0] rs;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] imm_d;
  logic [ADDR_W-1:0] imm_a;
  logic [DATA_W-1:0] res;
  logic              cout;
  logic [2:0]        nf;
  logic              take;
  logic              is_mem;

  assign op     = ir[15:12];
  assign rd     = ir[8 +: RSEL_W];
  assign rs     = ir[4 +: RSEL_W];
  assign a      = regs[rd];
  assign b      = regs[rs];
  assign is_mem = (op == 4'h9) || (op == 4'hA);

  always_comb begin
    imm_d = '0;
    imm_a = '0;
    imm_d[IMD-1:0] = ir[IMD-1:0];
    imm_a[IMA-1:0] = ir[IMA-1:0];
  end

  // CMP shares the subtractor; carry is the unsigned borrow
  always_comb begin
    res  = '0;
    cout = 1'b0;
    case (op)
      4'h0:       {cout, res} = {1'b0, a} + {1'b0, b};
      4'h1, 4'hB: {cout, res} = {1'b0, a} - {1'b0, b};
      4'h2:       res = a & b;
      4'h3:       res = a | b;
      4'h4:       res = a ^ b;
      4'h5:       res = ~a;
      4'h6: begin
        res  = a << 1;
        cout = a[DATA_W-1];
      end
      4'h7: begin
        res  = a >> 1;
        cout = a[0];
      end
      default: ;
    endcase
  end

  assign nf = {res[DATA_W-1], cout, res == '0};

  always_comb begin
    take = 1'b1;
    case (ir[10:8])
      3'd0:    take = flags[0];
      3'd1:    take = !flags[0];
      3'd2:    take = flags[1];
      3'd3:    take = !flags[1];
      3'd4:    take = flags[2];
      3'd5:    take = !flags[2];
      default: take = 1'b1;
    endcase
  end

  // reset_n gates the fetch request so it drops the moment reset asserts
  assign imem_req   = (st == S_FETCH) && reset_n;
  assign imem_addr  = pc;
  assign dmem_req   = (st == S_MEM);
  assign dmem_we    = (st == S_MEM) && (op == 4'hA);
  assign dmem_addr  = imm_a;
  assign dmem_wdata = a;
  assign cpu_state  = st;
  assign halted     = (st == S_HALT);
  assign dbg_data   = regs[dbg_sel];
  assign retire     = ((st == S_EXEC) && !is_mem) ||
                      ((st == S_MEM) && dmem_ack);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st    <= S_FETCH;
      pc    <= '0;
      ir    <= '0;
      flags <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (st)
        S_FETCH: begin
          if (imem_ack) begin
            ir <= imem_rdata;
            pc <= pc + 1'b1;
            st <= S_EXEC;
          end
        end
        S_EXEC: begin
          st <= S_FETCH;
          if (!op[3]) begin
            regs[rd] <= res;
            flags    <= nf;
          end
          case (op)
            4'h8:       regs[rd] <= imm_d;
            4'h9, 4'hA: st <= S_MEM;
            4'hB:       flags <= nf;
            4'hC:       pc <= imm_a;
            4'hD:       if (take) pc <= imm_a;
            4'hF:       st <= S_HALT;
            default: ;
          endcase
        end
        S_MEM: begin
          if (dmem_ack) begin
            if (op == 4'h9) regs[rd] <= dmem_rdata;
            st <= S_FETCH;
          end
        end
        S_HALT: st <= S_HALT;
        default: st <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_boruss_cpu_core.sv
// tb_boruss_cpu_core: directed programs against an 8-bit core
// and a 16-bit/8-register core sharing clock and reset
module tb_boruss_cpu_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n = 1'b0;

  logic       imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
  logic [7:0] imem_addr, dmem_addr, dmem_wdata, dmem_rdata, pc;
  logic [15:0] imem_rdata;
  logic [2:0] cpu_state, flags;
  logic       halted, retire;
  logic [1:0] dbg_sel = 2'd0;
  logic [7:0] dbg_data;

  logic        imem_req_w, imem_ack_w, dmem_req_w, dmem_we_w, dmem_ack_w;
  logic [7:0]  imem_addr_w, dmem_addr_w, pc_w;
  logic [15:0] imem_rdata_w, dmem_wdata_w, dmem_rdata_w, dbg_data_w;
  logic [2:0]  cpu_state_w, flags_w;
  logic        halted_w, retire_w;
  logic [2:0]  dbg_sel_w = 3'd0;

  logic [15:0] imem [256];
  logic [7:0]  dmem [256];
  logic [15:0] imem_w [256];
  logic        man_mode = 1'b0;
  logic        man_ack = 1'b0;
  int          dmem_wait = 0;
  int          dcnt = 0;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] pc_trace [$];
  int         rt_cyc [$];

  assign imem_ack   = man_mode ? man_ack : imem_req;
  assign imem_rdata = imem[imem_addr];
  assign dmem_ack   = dmem_req && (dcnt >= dmem_wait);
  assign dmem_rdata = dmem[dmem_addr];

  always @(posedge clk) begin
    dcnt <= dmem_req ? dcnt + 1 : 0;
    if (dmem_req && dmem_we && dmem_ack) dmem[dmem_addr] <= dmem_wdata;
  end

  assign imem_ack_w   = imem_req_w;
  assign imem_rdata_w = imem_w[imem_addr_w];
  assign dmem_ack_w   = dmem_req_w;
  assign dmem_rdata_w = 16'h0000;

  boruss_cpu_core u_dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pc(pc), .cpu_state(cpu_state), .flags(flags),
    .halted(halted), .retire(retire),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  boruss_cpu_core #(.DATA_W(16), .ADDR_W(8), .NUM_REGS(8)) u_wide (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_ack(imem_ack_w), .imem_rdata(imem_rdata_w),
    .dmem_req(dmem_req_w), .dmem_we(dmem_we_w), .dmem_addr(dmem_addr_w),
    .dmem_wdata(dmem_wdata_w), .dmem_ack(dmem_ack_w),
    .dmem_rdata(dmem_rdata_w),
    .pc(pc_w), .cpu_state(cpu_state_w), .flags(flags_w),
    .halted(halted_w), .retire(retire_w),
    .dbg_sel(dbg_sel_w), .dbg_data(dbg_data_w)
  );

  task automatic fill_imem(input logic [15:0] w);
    for (int i = 0; i < 256; i++) imem[i] = w;
  endtask

  task automatic release_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run_prog(input int max, output bit to);
    bit prev;
    prev = 1'b0;
    pc_trace.delete();
    rt_cyc.delete();
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (prev) pc_trace.push_back(pc);
      prev = retire;
      if (retire) rt_cyc.push_back(i);
      if (halted) break;
    end
    to = !halted;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (pc !== 8'h00) begin
      n_err++; $display("FAIL reset_pc: got %0h want 0", pc);
    end
    n_vec++;
    if (cpu_state !== 3'd0) begin
      n_err++; $display("FAIL reset_state: got %0d want 0", cpu_state);
    end
    n_vec++;
    if (flags !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: got %b want 000", flags);
    end
    n_vec++;
    if ({imem_req, dmem_req, dmem_we} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_reqs: got %b want 000",
               {imem_req, dmem_req, dmem_we});
    end
    n_vec++;
    if ({retire, halted} !== 2'b00) begin
      n_err++; $display("FAIL reset_rt_halt: got %b want 00", {retire, halted});
    end
    for (int i = 0; i < 4; i++) begin
      dbg_sel = i[1:0];
      #1;
      n_vec++;
      if (dbg_data !== 8'h00) begin
        n_err++; $display("FAIL reset_r%0d: got %0h want 0", i, dbg_data);
      end
    end
  endtask

  task automatic test_alu();
    bit to;
    fill_imem(16'hF000);
    imem[0] = 16'h80F0;
    imem[1] = 16'h8120;
    imem[2] = 16'h0010;
    imem[3] = 16'hF000;
    release_reset();
    #1;
    n_vec++;
    if ({imem_req, imem_addr} !== {1'b1, 8'h00}) begin
      n_err++;
      $display("FAIL first_fetch: got req=%b addr=%0h want req=1 addr=0",
               imem_req, imem_addr);
    end
    run_prog(40, to);
    n_vec++;
    if (to !== 1'b0) begin
      n_err++; $display("FAIL alu_timeout: got halted=%b want 1", halted);
    end
    n_vec++;
    if (rt_cyc.size() !== 4) begin
      n_err++; $display("FAIL alu_retires: got %0d want 4", rt_cyc.size());
    end
    for (int i = 1; i < rt_cyc.size(); i++) begin
      n_vec++;
      if (rt_cyc[i] - rt_cyc[i-1] !== 2) begin
        n_err++;
        $display("FAIL alu_retire_gap%0d: got %0d want 2",
                 i, rt_cyc[i] - rt_cyc[i-1]);
      end
    end
    dbg_sel = 2'd0;
    #1;
    n_vec++;
    if (dbg_data !== 8'h10) begin
      n_err++; $display("FAIL alu_r0: got %0h want 10", dbg_data);
    end
    dbg_sel = 2'd1;
    #1;
    n_vec++;
    if (dbg_data !== 8'h20) begin
      n_err++; $display("FAIL alu_r1: got %0h want 20", dbg_data);
    end
    n_vec++;
    if (flags !== 3'b010) begin
      n_err++; $display("FAIL alu_flags: got %b want 010", flags);
    end
    n_vec++;
    if (pc !== 8'h04) begin
      n_err++; $display("FAIL alu_pc: got %0h want 4", pc);
    end
  endtask

  task automatic test_halt();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_vec++;
      if ({imem_req, dmem_req, retire, halted, cpu_state} !==
          {1'b0, 1'b0, 1'b0, 1'b1, 3'd3}) begin
        n_err++;
        $display("FAIL halt_c%0d: got req=%b%b rt=%b h=%b st=%0d want 00 0 1 3",
                 i, imem_req, dmem_req, retire, halted, cpu_state);
      end
    end
  endtask

  task automatic test_branch();
    bit to;
    fill_imem(16'hF000);
    imem[0] = 16'h8205;
    imem[1] = 16'h8305;
    imem[2] = 16'hB230;
    imem[3] = 16'hD130;
    imem[4] = 16'hD040;
    imem[8'h40] = 16'hF000;
    release_reset();
    run_prog(60, to);
    n_vec++;
    if (to !== 1'b0) begin
      n_err++; $display("FAIL br_timeout: got halted=%b want 1", halted);
    end
    n_vec++;
    if (pc_trace.size() !== 6) begin
      n_err++; $display("FAIL br_count: got %0d want 6", pc_trace.size());
    end
    n_vec++;
    if (pc_trace[3] !== 8'h04) begin
      n_err++; $display("FAIL br_not_taken_pc: got %0h want 4", pc_trace[3]);
    end
    n_vec++;
    if (pc_trace[4] !== 8'h40) begin
      n_err++; $display("FAIL br_taken_pc: got %0h want 40", pc_trace[4]);
    end
    n_vec++;
    if (flags !== 3'b001) begin
      n_err++; $display("FAIL br_flags: got %b want 001", flags);
    end
    dbg_sel = 2'd2;
    #1;
    n_vec++;
    if (dbg_data !== 8'h05) begin
      n_err++; $display("FAIL br_r2: got %0h want 5", dbg_data);
    end
  endtask

  task automatic test_store();
    int run;
    int first_len;
    int bad;
    logic [2:0] fell_state;
    run = 0;
    first_len = -1;
    bad = 0;
    fell_state = 3'd7;
    fill_imem(16'hF000);
    for (int i = 0; i < 256; i++) dmem[i] = 8'h00;
    imem[0] = 16'h825A;
    imem[1] = 16'hA280;
    imem[2] = 16'h9380;
    imem[3] = 16'hF000;
    dmem_wait = 3;
    release_reset();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (dmem_req) begin
        run++;
        if (first_len < 0 &&
            (dmem_addr !== 8'h80 || dmem_wdata !== 8'h5A || dmem_we !== 1'b1))
          bad++;
      end else begin
        if (run > 0 && first_len < 0) begin
          first_len = run;
          fell_state = cpu_state;
        end
        run = 0;
      end
      if (halted) break;
    end
    dmem_wait = 0;
    n_vec++;
    if (halted !== 1'b1) begin
      n_err++; $display("FAIL st_timeout: got halted=%b want 1", halted);
    end
    n_vec++;
    if (first_len !== 4) begin
      n_err++; $display("FAIL st_req_cycles: got %0d want 4", first_len);
    end
    n_vec++;
    if (bad !== 0) begin
      n_err++; $display("FAIL st_stable: got %0d bad cycles want 0", bad);
    end
    n_vec++;
    if (fell_state !== 3'd0) begin
      n_err++; $display("FAIL st_next_state: got %0d want 0", fell_state);
    end
    n_vec++;
    if (dmem[8'h80] !== 8'h5A) begin
      n_err++; $display("FAIL st_mem: got %0h want 5a", dmem[8'h80]);
    end
    dbg_sel = 2'd3;
    #1;
    n_vec++;
    if (dbg_data !== 8'h5A) begin
      n_err++; $display("FAIL ld_r3: got %0h want 5a", dbg_data);
    end
  endtask

  task automatic test_reset_mid();
    man_mode = 1'b1;
    man_ack = 1'b0;
    release_reset();
    repeat (2) @(negedge clk);
    n_vec++;
    if ({imem_req, cpu_state} !== {1'b1, 3'd0}) begin
      n_err++;
      $display("FAIL rm_wait: got req=%b st=%0d want 1 0", imem_req, cpu_state);
    end
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (imem_req !== 1'b0) begin
      n_err++; $display("FAIL rm_drop: got req=%b want 0", imem_req);
    end
    dbg_sel = 2'd2;
    #1;
    n_vec++;
    if (dbg_data !== 8'h00) begin
      n_err++; $display("FAIL rm_regs_clr: got %0h want 0", dbg_data);
    end
    @(negedge clk);
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    n_vec++;
    if ({cpu_state, pc, retire} !== {3'd0, 8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL rm_late_ack: got st=%0d pc=%0h rt=%b want 0 0 0",
               cpu_state, pc, retire);
    end
    reset_n = 1'b1;
    #1;
    n_vec++;
    if ({imem_req, imem_addr} !== {1'b1, 8'h00}) begin
      n_err++;
      $display("FAIL rm_refetch: got req=%b addr=%0h want 1 0",
               imem_req, imem_addr);
    end
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    n_vec++;
    if ({cpu_state, pc} !== {3'd1, 8'h01}) begin
      n_err++;
      $display("FAIL rm_fetch_done: got st=%0d pc=%0h want 1 1", cpu_state, pc);
    end
    man_mode = 1'b0;
  endtask

  task automatic test_wrap();
    bit to;
    fill_imem(16'hF000);
    imem[0] = 16'hD110;
    imem[1] = 16'hF000;
    imem[8'h10] = 16'hC0FF;
    imem[8'hFF] = 16'hB000;
    release_reset();
    run_prog(60, to);
    n_vec++;
    if (to !== 1'b0) begin
      n_err++; $display("FAIL wrap_timeout: got halted=%b want 1", halted);
    end
    n_vec++;
    if (pc_trace[0] !== 8'h10) begin
      n_err++; $display("FAIL wrap_bnz: got %0h want 10", pc_trace[0]);
    end
    n_vec++;
    if (pc_trace[1] !== 8'hFF) begin
      n_err++; $display("FAIL wrap_jmp: got %0h want ff", pc_trace[1]);
    end
    n_vec++;
    if (pc_trace[2] !== 8'h00) begin
      n_err++; $display("FAIL wrap_pc: got %0h want 0", pc_trace[2]);
    end
    n_vec++;
    if (pc_trace[3] !== 8'h01) begin
      n_err++; $display("FAIL wrap_bnz_nt: got %0h want 1", pc_trace[3]);
    end
  endtask

  task automatic test_wide();
    release_reset();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (halted_w) break;
    end
    n_vec++;
    if ({halted_w, cpu_state_w} !== {1'b1, 3'd3}) begin
      n_err++;
      $display("FAIL wide_halt: got h=%b st=%0d want 1 3", halted_w, cpu_state_w);
    end
    dbg_sel_w = 3'd0;
    #1;
    n_vec++;
    if (dbg_data_w !== 16'hFFFF) begin
      n_err++; $display("FAIL wide_r0: got %0h want ffff", dbg_data_w);
    end
    dbg_sel_w = 3'd6;
    #1;
    n_vec++;
    if (dbg_data_w !== 16'h0001) begin
      n_err++; $display("FAIL wide_r6: got %0h want 1", dbg_data_w);
    end
    n_vec++;
    if (flags_w !== 3'b110) begin
      n_err++; $display("FAIL wide_flags: got %b want 110", flags_w);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem_w[i] = 16'hF000;
    imem_w[0] = 16'h8000;
    imem_w[1] = 16'h8601;
    imem_w[2] = 16'h1060;
    imem_w[3] = 16'hF000;
    fill_imem(16'hF000);
    test_reset();
    test_alu();
    test_halt();
    test_branch();
    test_store();
    test_reset_mid();
    test_wrap();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 want finish");
    $fatal(1);
  end

endmodule
